osc_freq_counter: RTL and testbench
===================================

Name: osc_freq_counter

Overview:
- Wishbone-slave frequency counter that consumes the output of one on-chip ring oscillator macro and reports edges counted over a programmable gate window of wb_clk_i cycles.
- Drives the oscillator enable and raises an interrupt on measurement completion.
- Sits between the wishbone bus and an osc instance, one counter per oscillator.
- Oscillator frequency must be below wb_clk_i/2.

Parameters:
- BASE_ADDR, 32'h3000_0000, wishbone base; block decodes BASE_ADDR+0x00..0x0C (adr[3:2]), ignores adr[31:4] mismatch.
- CNT_W, 24, width of edge counter and COUNT result.
- GATE_W, 24, width of gate length register.

Ports:
- wb_clk_i  in  1  sole clock
- wb_rst_ni  in  1  asynchronous active-low reset
- wbs_stb_i  in  1  wishbone strobe
- wbs_cyc_i  in  1  wishbone cycle
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte selects (writes honoured per byte)
- wbs_adr_i  in  32  address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- osc_in  in  1  asynchronous oscillator output
- osc_en  out  1  oscillator enable (to osc.osc_en)
- irq  out  1  measurement-done interrupt, level

Behaviour:
- Reset (async on wb_rst_ni low): wbs_ack_o=0, wbs_dat_o=0, osc_en=0, irq=0, CTRL=0, GATE=1000, COUNT=0, STATUS=0, FSM=IDLE, synchronizer flops=0.
- Registers:
  - 0x00 CTRL rw: bit0 START (write-1 pulse, reads 0), bit1 OSC_EN, bit2 CONT, bit3 IRQ_EN.
  - 0x04 GATE rw: [GATE_W-1:0].
  - 0x08 COUNT ro.
  - 0x0C STATUS: bit0 BUSY ro, bit1 DONE w1c, bit2 OVF w1c, bit3 ERR w1c.
- Wishbone: ack asserted exactly one cycle, in the cycle after stb&cyc&!ack is sampled; no back-to-back ack; read data valid with ack, 0 otherwise; unmapped offsets read 0, writes dropped.
- osc_en = CTRL.OSC_EN directly.
- osc_in passes a 2-flop synchronizer plus one history flop; rise = s2 & !s3.
- FSM:
  - IDLE: on START write with GATE!=0 -> load remain=GATE, edge_cnt=0, BUSY=1, -> MEAS. START with GATE==0 -> set ERR, stay IDLE.
  - MEAS: each cycle edge_cnt += rise (saturating at 2^CNT_W-1; saturation sets OVF); remain -= 1. In the cycle remain==1: COUNT <= edge_cnt + rise (saturated), DONE=1. If CONT=1, reload remain=GATE and edge_cnt=0 the same cycle with no dead cycle; else BUSY=0 -> IDLE.
  - Latency: COUNT updates exactly GATE cycles after the START write ack cycle.
- START while BUSY: ignored.
- Clearing CONT mid-window: current window completes, then IDLE.
- Clearing OSC_EN does not abort a measurement.
- GATE write during MEAS takes effect at next reload only.
- DONE set and W1C in the same cycle: set wins.
- Async reset mid-measurement: returns to IDLE, COUNT=0, no irq.

Optional Feature:
- FREQ_CNT_IRQ_EN defined: irq = STATUS.DONE & CTRL.IRQ_EN, registered, deasserts the cycle after DONE clears.
- Not defined: irq tied 0, CTRL.IRQ_EN reads 0 and writes are ignored.

Test Plan:
- Reset then read all four offsets -> 0x0, 0x3E8, 0x0, 0x0; osc_en=0; every access acked in exactly one cycle.
- GATE=100, osc_in period 10 wb cycles, START -> BUSY=1 for 100 cycles, then COUNT=10, DONE=1, irq=1 (IRQ_EN=1, macro defined); W1C DONE -> irq=0 next cycle.
- CONT=1, GATE=50, osc period 5 -> COUNT=10 on every window, updated every 50 cycles, no gap; clear CONT -> one more update, then BUSY=0.
- CNT_W=4, GATE=100, osc period 4 -> COUNT=15, OVF=1.
- GATE=0, START -> ERR=1, BUSY=0, COUNT unchanged; START while BUSY -> window end unchanged.
- Reset pulse at cycle 40 of a 100-cycle window -> all outputs return to reset values, no DONE, and a fresh START measures correctly.

Source files
------------

// File: rtl/osc_freq_counter.sv
// Wishbone-slave ring-oscillator frequency counter: counts synchronised osc_in rising edges
// over a GATE-cycle window. Define FREQ_CNT_IRQ_EN to enable the level interrupt.
module osc_freq_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned CNT_W     = 24,
    parameter int unsigned GATE_W    = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        osc_in,
    output logic        osc_en,
    output logic        irq
);

    typedef enum logic [0:0] {StIdle, StMeas} state_e;

    localparam logic [GATE_W-1:0] GateRst = GATE_W'(1000);
    localparam logic [CNT_W-1:0]  CntMax  = '1;

    state_e            state_q, state_d;
    logic              ack_q, ack_d;
    logic [31:0]       dat_q, dat_d, rdata, gate_wide;
    logic              osc_en_q, osc_en_d, cont_q, cont_d, irq_en_q, irq_en_d;
    logic [GATE_W-1:0] gate_q, gate_d, remain_q, remain_d;
    logic [CNT_W-1:0]  count_q, count_d, edge_q, edge_d, edge_sum;
    logic              done_q, done_d, ovf_q, ovf_d, err_q, err_d;
    logic              done_set, ovf_set, err_set;
    logic              s1_q, s2_q, s3_q, rise;
    logic              req, hit, wr, wr_ctrl, wr_gate, wr_stat, start, busy;
    logic              unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    assign req     = wbs_stb_i & wbs_cyc_i & ~ack_q;
    assign hit     = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign wr      = req & wbs_we_i & hit;
    assign wr_ctrl = wr & (wbs_adr_i[3:2] == 2'd0) & wbs_sel_i[0];
    assign wr_gate = wr & (wbs_adr_i[3:2] == 2'd1);
    assign wr_stat = wr & (wbs_adr_i[3:2] == 2'd3) & wbs_sel_i[0];
    assign start   = wr_ctrl & wbs_dat_i[0];
    assign busy    = (state_q == StMeas);
    assign rise    = s2_q & ~s3_q;

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign osc_en    = osc_en_q;

    always_comb begin
        gate_wide = 32'(gate_q);
        for (int b = 0; b < 4; b++) begin
            if (wbs_sel_i[b]) gate_wide[8*b +: 8] = wbs_dat_i[8*b +: 8];
        end
    end

    always_comb begin
        rdata = '0;
        case (wbs_adr_i[3:2])
            2'd0:    rdata = {28'd0, irq_en_q, cont_q, osc_en_q, 1'b0};
            2'd1:    rdata = 32'(gate_q);
            2'd2:    rdata = 32'(count_q);
            default: rdata = {28'd0, err_q, ovf_q, done_q, busy};
        endcase
        if (!hit) rdata = '0;
        ack_d = req;
        dat_d = (req && !wbs_we_i) ? rdata : '0;
    end

    // Measurement FSM; saturating edge count, reload without a dead cycle in CONT mode.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        edge_d   = edge_q;
        count_d  = count_q;
        done_set = 1'b0;
        ovf_set  = 1'b0;
        err_set  = 1'b0;
        edge_sum = edge_q + CNT_W'(rise);
        if (rise && edge_q == CntMax) edge_sum = CntMax;
        case (state_q)
            StIdle: begin
                if (start) begin
                    if (gate_q != '0) begin
                        remain_d = gate_q;
                        edge_d   = '0;
                        state_d  = StMeas;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            StMeas: begin
                if (rise && edge_q == CntMax) ovf_set = 1'b1;
                if (remain_q == GATE_W'(1)) begin
                    count_d  = edge_sum;
                    done_set = 1'b1;
                    if (cont_q && gate_q != '0) begin
                        remain_d = gate_q;
                        edge_d   = '0;
                    end else begin
                        // A zero GATE picked up at a continuous reload is an error.
                        err_set = cont_q;
                        state_d = StIdle;
                    end
                end else begin
                    remain_d = remain_q - GATE_W'(1);
                    edge_d   = edge_sum;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        osc_en_d = wr_ctrl ? wbs_dat_i[1] : osc_en_q;
        cont_d   = wr_ctrl ? wbs_dat_i[2] : cont_q;
`ifdef FREQ_CNT_IRQ_EN
        irq_en_d = wr_ctrl ? wbs_dat_i[3] : irq_en_q;
`else
        irq_en_d = 1'b0;
`endif
        gate_d = wr_gate ? GATE_W'(gate_wide) : gate_q;
        done_d = (done_q & ~(wr_stat & wbs_dat_i[1])) | done_set;
        ovf_d  = (ovf_q & ~(wr_stat & wbs_dat_i[2])) | ovf_set;
        err_d  = (err_q & ~(wr_stat & wbs_dat_i[3])) | err_set;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= StIdle;
            ack_q    <= 1'b0;
            dat_q    <= '0;
            osc_en_q <= 1'b0;
            cont_q   <= 1'b0;
            irq_en_q <= 1'b0;
            gate_q   <= GateRst;
            remain_q <= '0;
            count_q  <= '0;
            edge_q   <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            s3_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            osc_en_q <= osc_en_d;
            cont_q   <= cont_d;
            irq_en_q <= irq_en_d;
            gate_q   <= gate_d;
            remain_q <= remain_d;
            count_q  <= count_d;
            edge_q   <= edge_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            s1_q     <= osc_in;
            s2_q     <= s1_q;
            s3_q     <= s2_q;
        end
    end

`ifdef FREQ_CNT_IRQ_EN
    logic irq_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) irq_q <= 1'b0;
        else            irq_q <= done_q & irq_en_q;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_osc_freq_counter.sv
// Directed bench for osc_freq_counter (CNT_W=4) with a queue of expected COUNT results.
module tb_osc_freq_counter;

    localparam logic [31:0] Base = 32'h3000_0000;
`ifdef FREQ_CNT_IRQ_EN
    localparam logic IrqOn = 1'b1;
`else
    localparam logic IrqOn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stb = 1'b0, cyc = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'hF;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat_o;
    logic        osc_in = 1'b0;
    logic        osc_en, irq;

    int n_tests = 0;
    int n_fail  = 0;
    int tick    = 0;
    int osc_period = 0;
    int phase   = 0;
    int e0;
    int exp_q[$];
    logic [31:0] rv;

    osc_freq_counter #(
        .BASE_ADDR(Base),
        .CNT_W    (4),
        .GATE_W   (24)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_ni(rst_n),
        .wbs_stb_i(stb),
        .wbs_cyc_i(cyc),
        .wbs_we_i (we),
        .wbs_sel_i(sel),
        .wbs_adr_i(adr),
        .wbs_dat_i(wdat),
        .wbs_ack_o(ack),
        .wbs_dat_o(rdat_o),
        .osc_in   (osc_in),
        .osc_en   (osc_en),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    // Oscillator model, periodic in wb cycles, changing away from the sampling edge.
    always @(negedge clk) begin
        if (osc_period == 0) begin
            phase  <= 0;
            osc_in <= 1'b0;
        end else begin
            phase  <= (phase >= osc_period - 1) ? 0 : phase + 1;
            osc_in <= (phase < osc_period / 2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] r);
        stb = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
        @(posedge clk); #1;
        check("ack_one_cycle", {31'd0, ack}, 32'd1);
        r = rdat_o;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_deassert", {31'd0, ack}, 32'd0);
        check("dat_idle_zero", rdat_o, 32'd0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        logic [31:0] dummy;
        xfer(1'b1, Base + off, d, dummy);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] off, input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, Base + off, 32'd0, r);
        check(tag, r, exp);
    endtask

    // Position so that the next transfer is sampled on absolute edge 'edge_n'.
    task automatic wait_to(input int edge_n);
        if (tick > edge_n - 1) check("schedule", tick, edge_n - 1);
        while (tick < edge_n - 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic cnt_at(input int edge_n);
        logic [31:0] r;
        int exp;
        wait_to(edge_n);
        xfer(1'b0, Base + 32'h8, 32'd0, r);
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            check("count", r, 32'(exp));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_osc_en", {31'd0, osc_en}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ack", {31'd0, ack}, 32'd0);
        rst_n = 1'b1;
        idle(1);
        rd_chk("rst_ctrl", 32'h0, 32'h0);
        rd_chk("rst_gate", 32'h4, 32'h3E8);
        rd_chk("rst_count", 32'h8, 32'h0);
        rd_chk("rst_status", 32'hC, 32'h0);
        begin
            xfer(1'b0, 32'h4000_0004, 32'd0, rv);
            check("unmapped_rd", rv, 32'h0);
        end

        // Single window: GATE=100, period 10
        osc_period = 10;
        wr(32'h4, 32'd100);
        idle(30);
        wr(32'h0, 32'hB);
        e0 = tick - 1;
        exp_q.push_back(10);
        check("osc_en_on", {31'd0, osc_en}, 32'd1);
        wait_to(e0 + 2);  rd_chk("ctrl_rb", 32'h0, IrqOn ? 32'hA : 32'h2);
        wait_to(e0 + 4);  rd_chk("busy_early", 32'hC, 32'h1);
        wait_to(e0 + 100); rd_chk("busy_last", 32'hC, 32'h1);
        cnt_at(e0 + 102);
        wait_to(e0 + 104); rd_chk("done_1", 32'hC, 32'h2);
        check("irq_set", {31'd0, irq}, {31'd0, IrqOn});
        wr(32'hC, 32'h2);
        check("irq_clr", {31'd0, irq}, 32'd0);
        rd_chk("done_w1c", 32'hC, 32'h0);

        // Continuous: GATE=50, period 5
        osc_period = 5;
        wr(32'h4, 32'd50);
        idle(30);
        wr(32'h0, 32'h7);
        e0 = tick - 1;
        repeat (3) exp_q.push_back(10);
        for (int k = 1; k <= 2; k++) begin
            wait_to(e0 + 50 * k);     rd_chk("cont_busy", 32'hC, 32'h1);
            wait_to(e0 + 50 * k + 2); rd_chk("cont_done", 32'hC, 32'h3);
            cnt_at(e0 + 50 * k + 4);
            wait_to(e0 + 50 * k + 6); wr(32'hC, 32'h2);
        end
        wait_to(e0 + 108); wr(32'h0, 32'h2);
        wait_to(e0 + 150); rd_chk("cont_last_busy", 32'hC, 32'h1);
        wait_to(e0 + 152); rd_chk("cont_stop", 32'hC, 32'h2);
        cnt_at(e0 + 154);
        wait_to(e0 + 202); rd_chk("cont_idle", 32'hC, 32'h2);

        // Saturation: CNT_W=4, period 4 over 100 cycles
        wr(32'hC, 32'hE);
        osc_period = 4;
        wr(32'h4, 32'd100);
        idle(30);
        wr(32'h0, 32'h3);
        e0 = tick - 1;
        exp_q.push_back(15);
        cnt_at(e0 + 102);
        wait_to(e0 + 104); rd_chk("ovf_set", 32'hC, 32'h6);
        wr(32'hC, 32'h4);
        rd_chk("ovf_w1c", 32'hC, 32'h2);
        wr(32'hC, 32'h2);

        // GATE=0 error, then START while busy
        wr(32'h4, 32'd0);
        wr(32'h0, 32'h3);
        rd_chk("err_set", 32'hC, 32'h8);
        rd_chk("err_count_kept", 32'h8, 32'd15);
        wr(32'hC, 32'h8);
        rd_chk("err_w1c", 32'hC, 32'h0);
        osc_period = 20;
        wr(32'h4, 32'd100);
        idle(40);
        wr(32'h0, 32'h3);
        e0 = tick - 1;
        exp_q.push_back(5);
        wait_to(e0 + 30);  wr(32'h0, 32'h3);
        wait_to(e0 + 100); rd_chk("restart_busy", 32'hC, 32'h1);
        cnt_at(e0 + 102);
        wait_to(e0 + 104); rd_chk("restart_done", 32'hC, 32'h2);
        wr(32'hC, 32'h2);

        // Async reset at cycle 40 of a window
        osc_period = 10;
        wr(32'h4, 32'd100);
        idle(30);
        wr(32'h0, 32'hB);
        e0 = tick - 1;
        wait_to(e0 + 41);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_ack", {31'd0, ack}, 32'd0);
        check("mid_rst_dat", rdat_o, 32'd0);
        check("mid_rst_osc_en", {31'd0, osc_en}, 32'd0);
        check("mid_rst_irq", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rd_chk("mid_rst_ctrl", 32'h0, 32'h0);
        rd_chk("mid_rst_gate", 32'h4, 32'h3E8);
        rd_chk("mid_rst_count", 32'h8, 32'h0);
        rd_chk("mid_rst_status", 32'hC, 32'h0);
        idle(80);
        rd_chk("mid_rst_no_done", 32'hC, 32'h0);
        check("mid_rst_no_irq", {31'd0, irq}, 32'd0);
        wr(32'h4, 32'd100);
        idle(5);
        wr(32'h0, 32'hB);
        e0 = tick - 1;
        exp_q.push_back(10);
        cnt_at(e0 + 102);
        wait_to(e0 + 104); rd_chk("fresh_done", 32'hC, 32'h2);
        check("fresh_irq", {31'd0, irq}, {31'd0, IrqOn});

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
